// File: rtl/multicycle_r_proc_pkg.sv
// Shared definitions for the multicycle R-type processor: FSM encoding,
// instruction field codes and the ALU select map.
package multicycle_r_proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_NAND = 4'd8,
    ALU_XNOR = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_ROL  = 4'd12,
    ALU_ROR  = 4'd13
  } alu_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_MUL  = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_NAND = 6'b101000;
  localparam logic [5:0] FN_XNOR = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ROL  = 6'b111000;
  localparam logic [5:0] FN_ROR  = 6'b110000;

  typedef struct packed {
    logic     valid;
    alu_sel_e sel;
    logic     has_dest;
  } fn_dec_t;

  // mul and div produce a result in alu_out but never write a register
  function automatic fn_dec_t decode_funct(input logic [5:0] fn);
    fn_dec_t d;
    d.valid    = 1'b1;
    d.sel      = ALU_ADD;
    d.has_dest = 1'b1;
    case (fn)
      FN_ADD:  d.sel = ALU_ADD;
      FN_SUB:  d.sel = ALU_SUB;
      FN_MUL:  begin d.sel = ALU_MUL; d.has_dest = 1'b0; end
      FN_DIV:  begin d.sel = ALU_DIV; d.has_dest = 1'b0; end
      FN_AND:  d.sel = ALU_AND;
      FN_OR:   d.sel = ALU_OR;
      FN_XOR:  d.sel = ALU_XOR;
      FN_NOR:  d.sel = ALU_NOR;
      FN_NAND: d.sel = ALU_NAND;
      FN_XNOR: d.sel = ALU_XNOR;
      FN_SLL:  d.sel = ALU_SLL;
      FN_SRL:  d.sel = ALU_SRL;
      FN_ROL:  d.sel = ALU_ROL;
      FN_ROR:  d.sel = ALU_ROR;
      default: begin d.valid = 1'b0; d.has_dest = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_r_proc_alu.sv
// Combinational unsigned ALU; shift and rotate amounts are taken modulo DATA_W
// so non power-of-two widths still rotate over the whole word.
module alu_param
  import multicycle_r_proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_sel_e            sel,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          shamt,
  output logic [DATA_W-1:0]   y
);

  logic [5:0] sh;
  logic [5:0] sh_inv;

  always_comb begin
    sh     = 6'({27'd0, shamt} % 32'(DATA_W));
    sh_inv = 6'(DATA_W) - sh;
    y      = '0;
    case (sel)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_MUL:  y = a * b;
      ALU_DIV:  y = (b == '0) ? '1 : a / b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_NAND: y = ~(a & b);
      ALU_XNOR: y = ~(a ^ b);
      ALU_SLL:  y = a << sh;
      ALU_SRL:  y = a >> sh;
      // a shift by the full width yields zero, so sh == 0 rotates cleanly
      ALU_ROL:  y = (a << sh) | (a >> sh_inv);
      ALU_ROR:  y = (a >> sh) | (a << sh_inv);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_r_proc.sv
// Four-cycle R-type processor with local instruction memory and register file.
// state  | meaning
// IDLE   | parked; imem writable; leaves on run
// FETCH  | IR <= imem[pc], or back to IDLE if run is low
// DECODE | rd1/rd2 <= regs[rs]/regs[rt]
// EXEC   | alu_out <= ALU result, flag illegal, or go to HALT
// WB     | register write, pc+1, retired+1
// HALT   | stopped until reset; imem writable
module multicycle_r_proc
  import multicycle_r_proc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 256,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int RA_W      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] alu_out,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       retired
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, alu_q, alu_d;
  logic              illegal_q, illegal_d;
  logic [15:0]       retired_q, retired_d;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              rf_we;

  logic [5:0]        opcode, funct;
  logic [RA_W-1:0]   rs, rt, rd;
  logic [4:0]        shamt;
  fn_dec_t           fn;
  logic              is_legal;
  logic [DATA_W-1:0] alu_y;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[21 +: RA_W];
  assign rt       = ir_q[16 +: RA_W];
  assign rd       = ir_q[11 +: RA_W];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign fn       = decode_funct(funct);
  assign is_legal = (opcode == OP_RTYPE) && fn.valid;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .sel   (fn.sel),
    .a     (rd1_q),
    .b     (rd2_q),
    .shamt (shamt),
    .y     (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (!run) begin
          state_d = S_IDLE;
        end else begin
          ir_d    = imem[pc_q];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rd1_d   = regs_q[rs];
        rd2_d   = regs_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          if (is_legal) alu_d = alu_y;
          else          illegal_d = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        // register 0 is never written so it always reads zero
        rf_we     = is_legal && fn.has_dest && (rd != '0);
        pc_d      = pc_q + 1'b1;
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // reset wins over a pending writeback, which aborts the instruction in WB
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd] <= alu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we && (state_q == S_IDLE || state_q == S_HALT))
      imem[imem_addr] <= imem_wdata;
  end

  assign pc      = pc_q;
  assign rd1     = rd1_q;
  assign rd2     = rd2_q;
  assign alu_out = alu_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_r_proc.sv
// Scoreboard bench: a program-level reference model predicts every writeback,
// and a monitor compares them as the processor reaches WB.
module tb_multicycle_r_proc;

  localparam int DW = 16;
  localparam int NR = 32;
  localparam int ID = 256;
  localparam int PW = 8;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  localparam int F_ADD = 32, F_SUB = 34, F_MUL = 24, F_DIV = 26, F_AND = 36,
                 F_OR = 37, F_XOR = 38, F_NOR = 39, F_NAND = 40, F_XNOR = 42,
                 F_SLL = 0, F_SRL = 2, F_ROL = 56, F_ROR = 48;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, imem_we = 1'b0;
  logic [PW-1:0] imem_addr = '0;
  logic [31:0] imem_wdata = '0;
  logic [PW-1:0] pc;
  logic [DW-1:0] rd1, rd2, alu_out;
  logic [2:0] state;
  logic halted, illegal;
  logic [15:0] retired;

  multicycle_r_proc #(.DATA_W(DW), .NREGS(NR), .IMEM_DEPTH(ID)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .pc(pc), .rd1(rd1),
    .rd2(rd2), .alu_out(alu_out), .state(state), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc; int unsigned rd1; int unsigned rd2; int unsigned alu;
    bit chk_alu; bit ill; int ret;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] m_imem [ID];
  logic [31:0] prog[$];
  int n_cmp = 0, n_bad = 0;
  int exp_pc, exp_ret;
  bit exp_ill;
  int cyc = 0, prev_wb = 0;
  bit have_prev = 0, idle_seen = 0;
  int fn_list[14] = '{F_ADD, F_SUB, F_MUL, F_DIV, F_AND, F_OR, F_XOR, F_NOR,
                      F_NAND, F_XNOR, F_SLL, F_SRL, F_ROL, F_ROR};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r(input int fn, input int rd, input int rs,
                                    input int rt, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  // unsigned arithmetic on DW-bit words; returns 0 for an unlisted funct
  function automatic bit ref_alu(input int fn, input int unsigned a,
                                 input int unsigned b, input int sh,
                                 output int unsigned y);
    int s;
    int unsigned m;
    s = sh % DW;
    m = (1 << DW) - 1;
    y = 0;
    case (fn)
      F_ADD:  y = (a + b) & m;
      F_SUB:  y = (a - b) & m;
      F_MUL:  y = (a * b) & m;
      F_DIV:  y = (b == 0) ? m : a / b;
      F_AND:  y = a & b;
      F_OR:   y = a | b;
      F_XOR:  y = a ^ b;
      F_NOR:  y = ~(a | b) & m;
      F_NAND: y = ~(a & b) & m;
      F_XNOR: y = ~(a ^ b) & m;
      F_SLL:  y = (a * (1 << s)) & m;
      F_SRL:  y = a / (1 << s);
      F_ROL:  for (int i = 0; i < DW; i++) if (a[i]) y |= 1 << ((i + s) % DW);
      F_ROR:  for (int i = 0; i < DW; i++) if (a[(i + s) % DW]) y |= 1 << i;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // run the whole program in the model from a clean reset, queueing each WB
  task automatic predict();
    int unsigned regs[NR];
    int p, ret, steps;
    bit ill;
    p = 0; ret = 0; steps = 0; ill = 0;
    foreach (regs[i]) regs[i] = 0;
    sbq.delete();
    while (steps < ID) begin
      logic [31:0] w;
      int op, rs, rt, rd, sh, fn;
      int unsigned y;
      bit legal;
      exp_t e;
      w = m_imem[p];
      op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
      rd = int'(w[15:11]); sh = int'(w[10:6]); fn = int'(w[5:0]);
      if (op == 63) break;
      y = 0;
      legal = (op == 0) && ref_alu(fn, regs[rs], regs[rt], sh, y);
      e.pc = p; e.rd1 = regs[rs]; e.rd2 = regs[rt]; e.ret = ret;
      if (legal) begin
        e.chk_alu = 1; e.alu = y;
        if (fn != F_MUL && fn != F_DIV && rd != 0) regs[rd] = y;
      end else begin
        e.chk_alu = 0; e.alu = 0; ill = 1;
      end
      e.ill = ill;
      sbq.push_back(e);
      p = (p + 1) % ID; ret++; steps++;
    end
    exp_pc = p; exp_ret = ret; exp_ill = ill;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (state == 3'd0) idle_seen = 1;
      if (state == 3'd4) begin
        if (sbq.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("wb_pc", pc, e.pc);
          check("wb_rd1", rd1, e.rd1);
          check("wb_rd2", rd2, e.rd2);
          if (e.chk_alu) check("wb_alu_out", alu_out, e.alu);
          check("wb_illegal", illegal, e.ill);
          check("wb_retired", retired, e.ret);
        end
        if (have_prev && !idle_seen) check("wb_spacing", cyc - prev_wb, 4);
        prev_wb = cyc; have_prev = 1; idle_seen = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1; run = 0; imem_we = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    have_prev = 0;
  endtask

  task automatic write_word(input int addr, input logic [31:0] data, input bit upd);
    imem_addr = PW'(addr); imem_wdata = data; imem_we = 1;
    @(posedge clk); #1;
    imem_we = 0;
    if (upd) m_imem[addr] = data;
  endtask

  task automatic load_prog();
    foreach (prog[i]) write_word(i, prog[i], 1);
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 3000) begin @(posedge clk); #1; n++; end
    if (!halted) check("halt_timeout", 0, 1);
  endtask

  task automatic finish_checks();
    check("halted", halted, 1);
    check("halt_pc", pc, exp_pc);
    check("halt_retired", retired, exp_ret);
    check("halt_illegal", illegal, exp_ill);
    check("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    foreach (m_imem[i]) m_imem[i] = 32'h0;

    do_reset();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_rd1", rd1, 0);
    check("rst_rd2", rd2, 0);
    check("rst_alu", alu_out, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);

    // directed program: build R20=2, R21=5 without immediates, then exercise ops
    prog = '{r(F_NOR, 1, 0, 0, 0), r(F_SUB, 2, 0, 1, 0), r(F_SLL, 20, 2, 2, 1),
             r(F_SLL, 3, 2, 2, 2), r(F_ADD, 21, 3, 2, 0), r(F_ADD, 22, 21, 20, 0),
             r(F_SLL, 22, 21, 21, 3), r(F_ROR, 22, 21, 21, 1), r(F_DIV, 23, 21, 0, 0),
             r(63, 24, 1, 1, 0), r(F_ADD, 24, 22, 20, 0), r(F_AND, 25, 23, 1, 0),
             HALT_W};
    load_prog();
    predict();
    run = 1;
    repeat (2) @(posedge clk);
    #1 write_word(10, HALT_W, 0);
    wait_halt();
    finish_checks();

    // halt at word 3, then imem write while halted must take effect
    do_reset();
    prog = '{r(F_SUB, 2, 0, 0, 0), r(F_NOR, 1, 0, 0, 0), r(F_ADD, 3, 1, 1, 0), HALT_W};
    load_prog();
    predict();
    run = 1;
    wait_halt();
    finish_checks();
    write_word(0, r(F_NOR, 7, 0, 0, 0), 1);
    do_reset();
    predict();
    run = 1;
    wait_halt();
    finish_checks();

    // drop run mid-program: park in IDLE at the next fetch with pc held
    do_reset();
    prog = '{r(F_NOR, 1, 0, 0, 0), r(F_SUB, 2, 0, 1, 0), r(F_SLL, 20, 2, 2, 1),
             r(F_SLL, 3, 2, 2, 2), r(F_ADD, 21, 3, 2, 0), r(F_ADD, 22, 21, 20, 0),
             r(F_SLL, 22, 21, 21, 3), r(F_ROR, 22, 21, 21, 1), r(F_DIV, 23, 21, 0, 0),
             r(63, 24, 1, 1, 0), r(F_ADD, 24, 22, 20, 0), r(F_AND, 25, 23, 1, 0),
             HALT_W};
    load_prog();
    predict();
    run = 1;
    n = 0;
    while (!(pc == 4 && state == 3'd2) && n < 500) begin @(posedge clk); #1; n++; end
    check("runlow_reach", (pc == 4 && state == 3'd2), 1);
    run = 0;
    repeat (8) @(posedge clk);
    #1;
    check("runlow_state", state, 0);
    check("runlow_pc", pc, 5);
    repeat (5) @(posedge clk);
    #1;
    check("runlow_pc_held", pc, 5);
    run = 1;
    wait_halt();
    finish_checks();

    // reset during WB of add to R22 aborts the write
    do_reset();
    prog = '{r(F_NOR, 1, 0, 0, 0), r(F_SUB, 2, 0, 1, 0), r(F_ADD, 22, 2, 2, 0),
             r(F_OR, 5, 22, 22, 0), HALT_W};
    load_prog();
    predict();
    run = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(state == 3'd4 && pc == 2) && n < 500);
    check("rstwb_reach", (state == 3'd4 && pc == 2), 1);
    reset = 1; run = 0;
    @(posedge clk); #1;
    check("rstwb_state", state, 0);
    check("rstwb_pc", pc, 0);
    check("rstwb_retired", retired, 0);
    reset = 0; have_prev = 0;
    sbq.delete();
    write_word(0, r(F_OR, 5, 22, 22, 0), 1);
    write_word(1, HALT_W, 1);
    predict();
    run = 1;
    wait_halt();
    finish_checks();

    // randomized program seeded with some nonzero constants
    do_reset();
    prog = '{r(F_NOR, 1, 0, 0, 0), r(F_SUB, 2, 0, 1, 0), r(F_SLL, 3, 2, 2, 5),
             r(F_ADD, 4, 3, 2, 0), r(F_ROR, 5, 4, 4, 3)};
    for (int i = 0; i < 60; i++) begin
      int k, rs, rt, rd, sh;
      k = $urandom_range(0, 99);
      rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
      rd = $urandom_range(0, 31); sh = $urandom_range(0, 31);
      if (k < 90)      prog.push_back(r(fn_list[$urandom_range(0, 13)], rd, rs, rt, sh));
      else if (k < 95) prog.push_back(r(1, rd, rs, rt, sh));
      else             prog.push_back({6'($urandom_range(1, 62)), 26'($urandom)});
    end
    prog.push_back(HALT_W);
    load_prog();
    predict();
    run = 1;
    wait_halt();
    finish_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_r_proc.md
MULTICYCLE_R_PROC -- requirements
Module: multicycle_r_proc

Interface
REQ-001 Parameter DATA_W, default 16: register and ALU datapath width; legal values 8..32.
REQ-002 Parameter NREGS, default 32: register count; power of two, 2..32; register address = low log2(NREGS) bits of each 5-bit field.
REQ-003 Parameter IMEM_DEPTH, default 256: instruction words; power of two; PC width PC_W = log2(IMEM_DEPTH).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 run  input  1  level; while high, the FSM leaves IDLE/continues; low parks the FSM at the next FETCH boundary.
REQ-007 imem_we  input  1  instruction-memory write strobe; honoured only in IDLE or HALT.
REQ-008 imem_addr  input  PC_W  instruction write address.
REQ-009 imem_wdata  input  32  instruction write data.
REQ-010 pc  output  PC_W  current instruction word address.
REQ-011 rd1, rd2  output  DATA_W each  latched rs and rt operands (the A/B registers).
REQ-012 alu_out  output  DATA_W  latched ALU result register.
REQ-013 state  output  3  FSM encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
REQ-014 halted  output  1  high while in HALT.
REQ-015 illegal  output  1  sticky; set by unsupported opcode/funct, cleared only by reset.
REQ-016 retired  output  16  count of instructions completed through WB, wraps at 2^16.

Function
REQ-017 The FSM SHALL go IDLE->FETCH when run=1, then FETCH->DECODE->EXEC->WB->FETCH; each instruction takes exactly 4 cycles.
REQ-018 In FETCH the IR SHALL latch imem[pc]; in WB, pc SHALL become pc+1 modulo IMEM_DEPTH (wraps from IMEM_DEPTH-1 to 0).
REQ-019 In DECODE rd1/rd2 SHALL latch regs[IR[25:21]] and regs[IR[20:16]].
REQ-020 In EXEC alu_out SHALL latch the result selected by funct IR[5:0]: 100000 add, 100010 sub, 011000 mul, 011010 div, 100100 and, 100101 or, 100110 xor, 100111 nor, 101000 nand, 101010 xnor, 000000 sll, 000010 srl, 111000 rol, 110000 ror.
REQ-021 Arithmetic SHALL be unsigned and truncated to DATA_W; mul keeps the low DATA_W bits.
REQ-022 div with B=0 SHALL produce all-ones with no other effect.
REQ-023 Shift/rotate amount SHALL be shamt IR[10:6] modulo DATA_W; rotates SHALL use the full DATA_W word.
REQ-024 In WB regs[IR[15:11]] SHALL be written with alu_out, except for mul/div (which have no destination) and any write to register 0, which SHALL be suppressed; register 0 always reads 0.
REQ-025 Opcode 111111 SHALL move EXEC->HALT with no writeback, no pc increment, and no retired increment.
REQ-026 Any other nonzero opcode or an unlisted funct SHALL set illegal and complete as a NOP: no register write; pc advances; retired increments.
REQ-027 If run is low on entry to FETCH, the FSM SHALL go to IDLE instead, with pc preserved.
REQ-028 HALT and IDLE SHALL be exited only via reset, or for IDLE, via run=1.
REQ-029 An imem_we asserted outside IDLE/HALT SHALL be ignored.
REQ-030 Register and instruction-memory reads SHALL be combinational from the array; writes SHALL be synchronous.

Reset
REQ-031 Reset SHALL set the FSM to IDLE and clear pc, IR, rd1, rd2, alu_out, illegal and retired to 0.
REQ-032 Reset SHALL clear every register to 0 and leave imem contents unchanged.
REQ-033 Reset asserted mid-instruction SHALL abort it, with no register write in that cycle.

Structure
REQ-034 The shared package SHALL hold the state encoding, the funct codes, the HALT opcode, and the 4-bit ALU select codes (add=0 ... ror=13).
REQ-035 The ALU SHALL be one combinational sub-module, alu_param, parametrised by DATA_W, with inputs sel/a/b/shamt and output y.

Verification
REQ-036 Preload R20=2, R21=5 through a program of addi-free register writes (or a backdoor); add R22,R21,R20 -> R22=7, retired=1, 4 cycles.
REQ-037 sll R22,R21,shamt=3 and ror R22,R21,shamt=1 with DATA_W=16 -> 0x0028, then 0x8002.
REQ-038 div R21/R0 -> alu_out=0xFFFF, no register written; illegal stays 0.
REQ-039 Funct 111111 in the program -> illegal=1, pc advances, a following add still executes correctly.
REQ-040 Opcode 111111 at word 3 -> halted=1, pc=3, retired=3; imem_we accepted afterwards.
REQ-041 Assert reset during WB of an add to R22 -> R22 stays 0, state=IDLE, pc=0; lower run mid-program -> IDLE at next FETCH, pc held.
